// File: rtl/tdc_pkg.sv
// tdc_pkg: shared constants and types for the hit readout arbiter.
package tdc_pkg;

  localparam int WIDTH    = 46;
  localparam int CH_W     = 6;
  localparam int TS_W     = 16;
  localparam int LOST_W   = 16;
  localparam int DEADTIME = 4;

  typedef struct packed {
    logic [CH_W-1:0] chan;
    logic [TS_W-1:0] ts;
  } hit_word_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_t;

  // Round-robin pointer advance: the channel after the last grant, wrapping at WIDTH.
  function automatic logic [CH_W-1:0] next_ptr(input logic [CH_W-1:0] g);
    return (g == CH_W'(WIDTH - 1)) ? '0 : g + 1'b1;
  endfunction

endpackage

// File: rtl/hit_readout_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin search. The first set request at or
// after i_ptr (wrapping modulo WIDTH) wins; both index and one-hot are given.
module rr_arbiter #(
  parameter int WIDTH = 46,
  parameter int CH_W  = 6
) (
  input  logic [WIDTH-1:0] i_req,
  input  logic [CH_W-1:0]  i_ptr,
  output logic             o_any,
  output logic [CH_W-1:0]  o_idx,
  output logic [WIDTH-1:0] o_gnt
);

  logic [CH_W:0]   w_sum;
  logic [CH_W-1:0] w_sel;

  // scan from the pointer outward; only the first hit is kept
  always_comb begin
    o_any = 1'b0;
    o_idx = '0;
    o_gnt = '0;
    w_sum = '0;
    w_sel = '0;
    for (int off = 0; off < WIDTH; off++) begin
      w_sum = {1'b0, i_ptr} + (CH_W + 1)'(off);
      if (w_sum >= (CH_W + 1)'(WIDTH)) begin
        w_sum = w_sum - (CH_W + 1)'(WIDTH);
      end
      w_sel = w_sum[CH_W-1:0];
      if (!o_any && i_req[w_sel]) begin
        o_any        = 1'b1;
        o_idx        = w_sel;
        o_gnt[w_sel] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hit_readout_arbiter.sv
// hit_readout_arbiter: synchronises the asynchronous hit latch bank, detects
// rising edges, holds one timestamped pending hit per channel and drains them
// round-robin onto a valid/ready stream. Collisions on a pending slot are
// counted in a saturating lost counter.
// Optional build macro HIT_DEADTIME_EN adds a per-channel holdoff of DEADTIME
// cycles after each captured or dropped hit.
module hit_readout_arbiter
  import tdc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  hit_in,
  input  logic [WIDTH-1:0]  enable_mask,
  input  logic              ts_clr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CH_W-1:0]   out_chan,
  output logic [TS_W-1:0]   out_ts,
  output logic [LOST_W-1:0] lost_cnt,
  output logic              busy
);

  localparam int DCNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0]  r_s1, r_s2, r_s3;
  logic [TS_W-1:0]   r_ts_cnt;
  logic [WIDTH-1:0]  r_pend;
  logic [TS_W-1:0]   r_ts_reg [WIDTH];
  logic [CH_W-1:0]   r_ptr;
  out_state_t        r_state, w_state_nxt;
  hit_word_t         r_word;
  logic [LOST_W-1:0] r_lost;

  logic [WIDTH-1:0]  w_event, w_holdoff, w_gnt_oh, w_clr;
  logic [WIDTH-1:0]  w_pend_kept, w_drop, w_capture;
  logic              w_any, w_load;
  logic [CH_W-1:0]   w_gnt_idx;
  logic [DCNT_W-1:0] w_drop_cnt;
  logic [LOST_W:0]   w_lost_sum;

  // two-flop synchroniser plus previous-sample register for edge detection
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
      r_s3 <= '0;
    end else begin
      r_s1 <= hit_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  // free-running coarse timestamp; wraps naturally at 2^TS_W
  always_ff @(posedge clk) begin
    if (!rst_n || ts_clr) r_ts_cnt <= '0;
    else                  r_ts_cnt <= r_ts_cnt + 1'b1;
  end

`ifdef HIT_DEADTIME_EN
  localparam int HOLD_W = (DEADTIME < 1) ? 1 : $clog2(DEADTIME + 1);
  logic [HOLD_W-1:0] r_hold [WIDTH];

  // a channel is held off while its counter is non-zero
  always_comb begin
    w_holdoff = '0;
    for (int i = 0; i < WIDTH; i++) w_holdoff[i] = (r_hold[i] != '0);
  end

  // reload on any accepted edge (captured or dropped), otherwise count down
  always_ff @(posedge clk) begin
    for (int i = 0; i < WIDTH; i++) begin
      if (!rst_n)            r_hold[i] <= '0;
      else if (w_event[i])   r_hold[i] <= HOLD_W'(DEADTIME);
      else if (w_holdoff[i]) r_hold[i] <= r_hold[i] - 1'b1;
    end
  end
`else
  assign w_holdoff = '0;
`endif

  assign w_event = r_s2 & ~r_s3 & enable_mask & ~w_holdoff;

  rr_arbiter #(
    .WIDTH (WIDTH),
    .CH_W  (CH_W)
  ) u_rr_arbiter (
    .i_req (r_pend),
    .i_ptr (r_ptr),
    .o_any (w_any),
    .o_idx (w_gnt_idx),
    .o_gnt (w_gnt_oh)
  );

  // the granted slot is freed before this cycle's events are considered, so a
  // same-cycle re-hit on the granted channel is captured rather than dropped
  assign w_load      = w_any && ((r_state == EMPTY) || out_ready);
  assign w_clr       = w_load ? w_gnt_oh : '0;
  assign w_pend_kept = r_pend & ~w_clr;
  assign w_drop      = w_event & w_pend_kept;
  assign w_capture   = w_event & ~w_pend_kept;

  // pending slots: clear on grant, then set on a new event
  always_ff @(posedge clk) begin
    if (!rst_n) r_pend <= '0;
    else        r_pend <= w_pend_kept | w_event;
  end

  // stamp freshly captured hits; a dropped hit keeps the original stamp
  always_ff @(posedge clk) begin
    for (int i = 0; i < WIDTH; i++) begin
      if (w_capture[i]) r_ts_reg[i] <= r_ts_cnt;
    end
  end

  // number of channels dropping a hit this cycle
  always_comb begin
    w_drop_cnt = '0;
    for (int i = 0; i < WIDTH; i++) w_drop_cnt = w_drop_cnt + DCNT_W'(w_drop[i]);
  end

  assign w_lost_sum = {1'b0, r_lost} + (LOST_W + 1)'(w_drop_cnt);

  // saturating lost-hit counter
  always_ff @(posedge clk) begin
    if (!rst_n)                  r_lost <= '0;
    else if (w_lost_sum[LOST_W]) r_lost <= '1;
    else                         r_lost <= w_lost_sum[LOST_W-1:0];
  end

  // output stage state register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= EMPTY;
    else        r_state <= w_state_nxt;
  end

  // output stage next state: fill when anything is pending, empty on a
  // handshake with nothing left to refill
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      EMPTY:   if (w_any) w_state_nxt = FULL;
      FULL:    if (out_ready && !w_any) w_state_nxt = EMPTY;
      default: w_state_nxt = EMPTY;
    endcase
  end

  // output word and round-robin pointer advance on every load
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_word <= '0;
      r_ptr  <= '0;
    end else if (w_load) begin
      r_word <= '{chan: w_gnt_idx, ts: r_ts_reg[w_gnt_idx]};
      r_ptr  <= next_ptr(w_gnt_idx);
    end
  end

  assign out_valid = (r_state == FULL);
  assign out_chan  = r_word.chan;
  assign out_ts    = r_word.ts;
  assign lost_cnt  = r_lost;
  assign busy      = (|r_pend) || out_valid;

endmodule

// File: tb/tb_hit_readout_arbiter.sv
// Bench for hit_readout_arbiter: directed vector table, hand sequences for the
// multi-cycle corners, and a randomized phase checked against a behavioural
// model of the capture/arbitration rules.
module tb_hit_readout_arbiter;
  import tdc_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [WIDTH-1:0]  hit_in;
  logic [WIDTH-1:0]  enable_mask;
  logic              ts_clr;
  logic              out_valid;
  logic              out_ready;
  logic [CH_W-1:0]   out_chan;
  logic [TS_W-1:0]   out_ts;
  logic [LOST_W-1:0] lost_cnt;
  logic              busy;

  always #5 clk = ~clk;

  hit_readout_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .hit_in      (hit_in),
    .enable_mask (enable_mask),
    .ts_clr      (ts_clr),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_chan    (out_chan),
    .out_ts      (out_ts),
    .lost_cnt    (lost_cnt),
    .busy        (busy)
  );

  int total = 0;
  int bad   = 0;

  // behavioural model state
  bit [WIDTH-1:0] m_s1, m_s2, m_s3, m_pend;
  int m_ts_reg [WIDTH];
  int m_ts, m_ptr, m_chan, m_out_ts, m_lost;
  bit m_valid;
`ifdef HIT_DEADTIME_EN
  int m_hold [WIDTH];
`endif

  int acc_chan [$];
  int acc_ts   [$];

  typedef struct {
    bit rst_n;
    int hit_ch;
    bit ready;
    bit e_valid;
    int e_chan;
    int e_ts;
    bit e_busy;
    int e_lost;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // one clock of the reference: consume/refill the output word, then capture
  function automatic void model_step();
    bit [WIDTH-1:0] ev;
    int g;
    if (!rst_n) begin
      m_s1 = '0; m_s2 = '0; m_s3 = '0; m_pend = '0;
      m_ts = 0; m_ptr = 0; m_valid = 0; m_chan = 0; m_out_ts = 0; m_lost = 0;
`ifdef HIT_DEADTIME_EN
      foreach (m_hold[i]) m_hold[i] = 0;
`endif
      return;
    end
    for (int i = 0; i < WIDTH; i++) begin
      ev[i] = m_s2[i] && !m_s3[i] && enable_mask[i];
`ifdef HIT_DEADTIME_EN
      if (m_hold[i] != 0) ev[i] = 1'b0;
`endif
    end
    if (m_valid && out_ready) m_valid = 0;
    if (!m_valid && m_pend != '0) begin
      g = m_ptr;
      while (!m_pend[g]) g = (g + 1) % WIDTH;
      m_valid = 1; m_chan = g; m_out_ts = m_ts_reg[g];
      m_pend[g] = 1'b0;
      m_ptr = (g + 1) % WIDTH;
    end
    for (int i = 0; i < WIDTH; i++) begin
      if (ev[i]) begin
        if (m_pend[i]) begin
          if (m_lost < 65535) m_lost++;
        end else begin
          m_pend[i] = 1'b1;
          m_ts_reg[i] = m_ts;
        end
      end
`ifdef HIT_DEADTIME_EN
      if (ev[i]) m_hold[i] = DEADTIME;
      else if (m_hold[i] > 0) m_hold[i]--;
`endif
    end
    m_s3 = m_s2; m_s2 = m_s1; m_s1 = hit_in;
    m_ts = ts_clr ? 0 : (m_ts + 1) % 65536;
  endfunction

  // drive-at-negedge, advance one edge, compare against the model
  task automatic cycle();
    if (out_valid && out_ready && rst_n) begin
      acc_chan.push_back(int'(out_chan));
      acc_ts.push_back(int'(out_ts));
    end
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("out_valid", out_valid, m_valid);
    check("out_chan", out_chan, m_chan);
    check("out_ts", out_ts, m_out_ts);
    check("lost_cnt", lost_cnt, m_lost);
    check("busy", busy, (m_pend != '0) || m_valid);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic check_word(input string name, input int k, input int ch, input int ts);
    check(name, (k < acc_chan.size()) ? acc_chan[k] : -1, ch);
    if (ts >= 0) check({name, "_ts"}, (k < acc_ts.size()) ? acc_ts[k] : -1, ts);
  endtask

  task automatic clear_acc();
    acc_chan.delete();
    acc_ts.delete();
  endtask

  int first_ts, lost_before, n;

  initial begin
    rst_n = 1'b0; hit_in = '0; enable_mask = '1; ts_clr = 1'b0; out_ready = 1'b0;

    // reset, then a single hit on ch 5 raised when ts_cnt is 8 -> stamped 10
    for (int r = 0; r < 14; r++) begin
      vecs[r] = '{rst_n: (r != 0), hit_ch: (r >= 9) ? 5 : -1, ready: (r == 13),
                  e_valid: (r == 12), e_chan: (r >= 12) ? 5 : 0,
                  e_ts: (r >= 12) ? 10 : 0, e_busy: (r == 11 || r == 12), e_lost: 0};
    end
    foreach (vecs[r]) begin
      rst_n = vecs[r].rst_n;
      hit_in = '0;
      if (vecs[r].hit_ch >= 0) hit_in[vecs[r].hit_ch] = 1'b1;
      out_ready = vecs[r].ready;
      cycle();
      check("vec_valid", out_valid, vecs[r].e_valid);
      check("vec_chan", out_chan, vecs[r].e_chan);
      check("vec_ts", out_ts, vecs[r].e_ts);
      check("vec_busy", busy, vecs[r].e_busy);
      check("vec_lost", lost_cnt, vecs[r].e_lost);
    end

    // three simultaneous hits drain back-to-back in channel order after reset
    hit_in = '0; out_ready = 1'b1; idle(2);
    rst_n = 1'b0; idle(1); rst_n = 1'b1; idle(1);
    clear_acc();
    hit_in[0] = 1'b1; hit_in[7] = 1'b1; hit_in[45] = 1'b1;
    idle(8);
    check("multi_count", acc_chan.size(), 3);
    check_word("multi_0", 0, 0, -1);
    check_word("multi_1", 1, 7, -1);
    check_word("multi_2", 2, 45, -1);
    check("multi_idle", out_valid, 0);

    // stalled output: third hit on ch 3 collides with the pending second one
    hit_in = '0; out_ready = 1'b0; idle(3);
    first_ts = (m_ts + 2) % 65536;
    for (int p = 0; p < 3; p++) begin
      hit_in[3] = 1'b1; idle(2);
      hit_in[3] = 1'b0; idle(2);
    end
    idle(20);
    check("stall_valid", out_valid, 1);
    check("stall_chan", out_chan, 3);
    check("stall_ts", out_ts, first_ts);
    check("stall_lost", lost_cnt, 1);
    clear_acc();
    out_ready = 1'b1; idle(4);
    check("stall_count", acc_chan.size(), 2);
    check_word("stall_w0", 0, 3, first_ts);
    check_word("stall_w1", 1, 3, -1);

    // pointer left at 44 by a grant on 43; pending 2 and 45 -> 45 first
    hit_in[43] = 1'b1; idle(6);
    clear_acc();
    hit_in = '0; hit_in[2] = 1'b1; hit_in[45] = 1'b1;
    idle(8);
    check("wrap_count", acc_chan.size(), 2);
    check_word("wrap_w0", 0, 45, -1);
    check_word("wrap_w1", 1, 2, -1);

    // masked channel produces neither a word nor a loss
    hit_in = '0; enable_mask[9] = 1'b0; idle(3);
    clear_acc();
    lost_before = m_lost;
    hit_in[9] = 1'b1; idle(8);
    check("mask_words", acc_chan.size(), 0);
    check("mask_lost", lost_cnt, lost_before);

    // reset while FULL with another hit pending discards everything
    enable_mask = '1; hit_in = '0; out_ready = 1'b0; idle(2);
    hit_in[11] = 1'b1; hit_in[12] = 1'b1;
    n = 0;
    while (!m_valid && n < 10) begin idle(1); n++; end
    check("full_before_rst", out_valid, 1);
    check("pend_before_rst", busy, 1);
    rst_n = 1'b0; hit_in = '0; idle(1);
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_chan", out_chan, 0);
    check("rst_lost", lost_cnt, 0);
    rst_n = 1'b1; idle(4);
    check("rst_stays_idle", busy, 0);

    // randomized traffic against the model
    for (int c = 0; c < 2500; c++) begin
      for (int i = 0; i < WIDTH; i++) begin
        if ($urandom_range(7) == 0) hit_in[i] = ~hit_in[i];
        enable_mask[i] = ($urandom_range(15) != 0);
      end
      out_ready = $urandom_range(1);
      ts_clr = ($urandom_range(200) == 0);
      rst_n = ($urandom_range(400) != 0);
      cycle();
    end
    rst_n = 1'b0; hit_in = '0; enable_mask = '1; ts_clr = 1'b0; out_ready = 1'b1;
    idle(1);
    rst_n = 1'b1; idle(3);

`ifdef HIT_DEADTIME_EN
    // edges 2 cycles apart: second suppressed; edge 5 cycles later accepted
    clear_acc();
    hit_in[1] = 1'b1; idle(1); hit_in[1] = 1'b0; idle(1);
    hit_in[1] = 1'b1; idle(1); hit_in[1] = 1'b0; idle(4);
    hit_in[1] = 1'b1; idle(1); hit_in[1] = 1'b0; idle(6);
    check("dt_count", acc_chan.size(), 2);
    check("dt_lost", lost_cnt, 0);
`endif

    // timestamp wrap: hits stamped 0xFFFF and then 0x0000
    ts_clr = 1'b1; idle(1); ts_clr = 1'b0;
    n = 0;
    while (m_ts != 16'hFFFD && n < 70000) begin idle(1); n++; end
    check("wrap_reached", (n < 70000), 1);
    clear_acc();
    hit_in[20] = 1'b1; idle(1);
    hit_in[21] = 1'b1; idle(6);
    check("tswrap_count", acc_chan.size(), 2);
    check_word("tswrap_w0", 0, 20, 16'hFFFF);
    check_word("tswrap_w1", 1, 21, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
